// File: rtl/clk_meter.sv
// clk_meter: measures phase, high time, low time and period of an asynchronous
// input against clk, with the phase taken from a rising edge on ref_in.
//
// state     | meaning
// IDLE      | waiting for start
// WAIT_REF  | waiting for a ref_in rising edge
// WAIT_RISE | ref seen, counting until sig_in rises (phase)
// HIGH      | sig high, counting until sig falls
// LOW       | sig low, counting until sig rises again
// DONE      | publish results for one cycle
module clk_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 65535
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             ref_in,
    input  logic             start,
    input  logic             cont,
    output logic             busy,
    output logic             meas_valid,
    output logic             timeout,
    output logic [CNT_W-1:0] phase_cnt,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] low_cnt,
    output logic [CNT_W-1:0] period_cnt
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_REF  = 3'd1,
        WAIT_RISE = 3'd2,
        HIGH      = 3'd3,
        LOW       = 3'd4,
        DONE      = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sig_sync_q, sig_sync_d;
    logic [SYNC_STAGES-1:0] ref_sync_q, ref_sync_d;
    logic sig_prev_q, sig_prev_d;
    logic ref_prev_q, ref_prev_d;
    logic sig_rise_q, sig_rise_d;
    logic sig_fall_q, sig_fall_d;
    logic ref_rise_q, ref_rise_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] phase_lat_q, phase_lat_d;
    logic [CNT_W-1:0] high_lat_q, high_lat_d;
    logic [CNT_W-1:0] low_lat_q, low_lat_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] low_q, low_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             meas_valid_q, meas_valid_d;
    logic             timeout_q, timeout_d;

    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W:0]   sum_full;
    logic             at_limit;
    logic             sig_lvl;
    logic             ref_lvl;

    // Both inputs see identical latency, so phase is not biased by conditioning.
    always_comb begin
        sig_sync_d = {sig_sync_q[SYNC_STAGES-2:0], sig_in};
        ref_sync_d = {ref_sync_q[SYNC_STAGES-2:0], ref_in};
        sig_lvl    = sig_sync_q[SYNC_STAGES-1];
        ref_lvl    = ref_sync_q[SYNC_STAGES-1];
        sig_prev_d = sig_lvl;
        ref_prev_d = ref_lvl;
        sig_rise_d = sig_lvl & ~sig_prev_q;
        sig_fall_d = ~sig_lvl & sig_prev_q;
        ref_rise_d = ref_lvl & ~ref_prev_q;
    end

    always_comb begin
        cnt_inc  = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
        at_limit = (cnt_q >= TO_VAL);
        sum_full = {1'b0, high_lat_q} + {1'b0, low_lat_q};
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        phase_lat_d  = phase_lat_q;
        high_lat_d   = high_lat_q;
        low_lat_d    = low_lat_q;
        phase_d      = phase_q;
        high_d       = high_q;
        low_d        = low_q;
        period_d     = period_q;
        meas_valid_d = 1'b0;
        timeout_d    = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = WAIT_REF;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT_REF: begin
                cnt_d = cnt_inc;
                if (ref_rise_q) begin
                    cnt_d = CNT_ONE;
                    if (sig_rise_q) begin
                        phase_lat_d = '0;
                        state_d     = HIGH;
                    end else begin
                        state_d = WAIT_RISE;
                    end
                end else if (at_limit) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                    cnt_d     = '0;
                end
            end
            WAIT_RISE: begin
                cnt_d = cnt_inc;
                if (sig_rise_q) begin
                    phase_lat_d = cnt_q;
                    cnt_d       = CNT_ONE;
                    state_d     = HIGH;
                end else if (at_limit) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                    cnt_d     = '0;
                end
            end
            HIGH: begin
                cnt_d = cnt_inc;
                if (sig_fall_q) begin
                    high_lat_d = cnt_q;
                    cnt_d      = CNT_ONE;
                    state_d    = LOW;
                end else if (at_limit) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                    cnt_d     = '0;
                end
            end
            LOW: begin
                cnt_d = cnt_inc;
                if (sig_rise_q) begin
                    low_lat_d = cnt_q;
                    cnt_d     = '0;
                    state_d   = DONE;
                end else if (at_limit) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                    cnt_d     = '0;
                end
            end
            DONE: begin
                phase_d      = phase_lat_q;
                high_d       = high_lat_q;
                low_d        = low_lat_q;
                period_d     = sum_full[CNT_W] ? CNT_MAX : sum_full[CNT_W-1:0];
                meas_valid_d = 1'b1;
                if (cont) begin
                    state_d = WAIT_REF;
                    cnt_d   = CNT_ONE;
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sig_sync_q   <= '0;
            ref_sync_q   <= '0;
            sig_prev_q   <= 1'b0;
            ref_prev_q   <= 1'b0;
            sig_rise_q   <= 1'b0;
            sig_fall_q   <= 1'b0;
            ref_rise_q   <= 1'b0;
            cnt_q        <= '0;
            phase_lat_q  <= '0;
            high_lat_q   <= '0;
            low_lat_q    <= '0;
            phase_q      <= '0;
            high_q       <= '0;
            low_q        <= '0;
            period_q     <= '0;
            meas_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sig_sync_q   <= sig_sync_d;
            ref_sync_q   <= ref_sync_d;
            sig_prev_q   <= sig_prev_d;
            ref_prev_q   <= ref_prev_d;
            sig_rise_q   <= sig_rise_d;
            sig_fall_q   <= sig_fall_d;
            ref_rise_q   <= ref_rise_d;
            cnt_q        <= cnt_d;
            phase_lat_q  <= phase_lat_d;
            high_lat_q   <= high_lat_d;
            low_lat_q    <= low_lat_d;
            phase_q      <= phase_d;
            high_q       <= high_d;
            low_q        <= low_d;
            period_q     <= period_d;
            meas_valid_q <= meas_valid_d;
            timeout_q    <= timeout_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign meas_valid = meas_valid_q;
    assign timeout    = timeout_q;
    assign phase_cnt  = phase_q;
    assign high_cnt   = high_q;
    assign low_cnt    = low_q;
    assign period_cnt = period_q;

endmodule
